// File: rtl/if_stage_pipe_pkg.sv
// Shared constants, fetch-queue entry type and branch-target helper for the fetch stage.
package if_pkg;
    localparam int INST_BYTES         = 4;
    localparam int DEF_INST_SIZE      = 32;
    localparam int DEF_PC_SIZE        = 32;
    localparam int DEF_BR_OFFSET_SIZE = 16;

    typedef struct packed {
        logic [DEF_PC_SIZE-1:0]   pc;
        logic [DEF_INST_SIZE-1:0] inst;
    } fetch_entry_t;

    // Callers zero-extend into 64 bits; off_bits selects where the offset's sign bit sits.
    function automatic logic [63:0] sext_target(input logic [63:0] br_pc,
                                                input logic [63:0] br_off,
                                                input int          off_bits);
        logic [63:0] off_sext;
        for (int i = 0; i < 64; i++)
            off_sext[i] = (i < off_bits) ? br_off[i] : br_off[off_bits-1];
        return br_pc + 64'(INST_BYTES) + (off_sext << 2);
    endfunction
endpackage

// File: rtl/if_stage_pipe_if.sv
// Fetch-stage bus: EX redirect, instruction-memory request/response and the ID handshake.
interface if_stage_pipe_if #(
    parameter int INST_SIZE      = 32,
    parameter int PC_SIZE        = 32,
    parameter int BR_OFFSET_SIZE = 16
);
    logic                      brTaken;
    logic [PC_SIZE-1:0]        brPC;
    logic [BR_OFFSET_SIZE-1:0] brOffset;
    logic                      imemReq;
    logic [PC_SIZE-1:0]        imemAddr;
    logic                      imemGnt;
    logic                      imemRspValid;
    logic [INST_SIZE-1:0]      imemRspData;
    logic                      outValid;
    logic                      outReady;
    logic [PC_SIZE-1:0]        PC;
    logic [INST_SIZE-1:0]      instruction;

    modport master (
        input  brTaken, brPC, brOffset, imemGnt, imemRspValid, imemRspData, outReady,
        output imemReq, imemAddr, outValid, PC, instruction
    );

    modport slave (
        output brTaken, brPC, brOffset, imemGnt, imemRspValid, imemRspData, outReady,
        input  imemReq, imemAddr, outValid, PC, instruction
    );
endinterface

// File: rtl/if_stage_pipe_fetch_fifo.sv
// Show-ahead synchronous FIFO with flush, holding fetched {pc, inst} entries.
module fetch_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = if_pkg::fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  entry_t                       data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output entry_t                       head_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t           mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    // The credit scheme in the parent must make a push into a full queue impossible.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(push_i && full));
endmodule

// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage: credit-limited sequential fetch, redirect squash, show-ahead queue to ID.
// Build option IF_FIFO_BYPASS_EN forwards a response straight to ID when the queue is empty.
module if_stage_pipe
    import if_pkg::*;
#(
    parameter int                  INST_SIZE      = DEF_INST_SIZE,
    parameter int                  PC_SIZE        = DEF_PC_SIZE,
    parameter int                  BR_OFFSET_SIZE = DEF_BR_OFFSET_SIZE,
    parameter int                  FIFO_DEPTH     = 4,
    parameter logic [PC_SIZE-1:0]  RESET_PC       = '0
) (
    input logic               clk,
    input logic               rst,
    if_stage_pipe_if.master   bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [PC_SIZE-1:0]   pc;
        logic [INST_SIZE-1:0] inst;
    } entry_t;

    logic [PC_SIZE-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d, drop_q, drop_d, fifo_count;
    logic               grant, rsp_keep, push, pop, fifo_empty;
    entry_t             rsp_entry, head, out_entry;

    assign target = PC_SIZE'(sext_target(64'(bus.brPC), 64'(bus.brOffset), BR_OFFSET_SIZE));

    // Credits cover both in-flight fetches (including wrong-path ones) and queued entries.
    assign bus.imemReq  = rst && !bus.brTaken &&
                          ((outstanding_q + fifo_count) < CNT_W'(FIFO_DEPTH));
    assign bus.imemAddr = fetch_pc_q;
    assign grant        = bus.imemReq && bus.imemGnt;

    assign rsp_keep  = bus.imemRspValid && (drop_q == '0) && !bus.brTaken;
    assign rsp_entry = '{pc: rsp_pc_q, inst: bus.imemRspData};
    assign pop       = !fifo_empty && bus.outReady && !bus.brTaken;

`ifdef IF_FIFO_BYPASS_EN
    logic bypass;
    assign bypass       = rsp_keep && fifo_empty;
    assign bus.outValid = !fifo_empty || bypass;
    assign out_entry    = bypass ? rsp_entry : head;
    assign push         = rsp_keep && !(bypass && bus.outReady);
`else
    assign bus.outValid = !fifo_empty;
    assign out_entry    = head;
    assign push         = rsp_keep;
`endif

    assign bus.PC          = out_entry.pc;
    assign bus.instruction = out_entry.inst;

    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(bus.imemRspValid);
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        if (bus.brTaken) begin
            fetch_pc_d = target;
            rsp_pc_d   = target;
            drop_d     = outstanding_d;
        end else begin
            if (grant)    fetch_pc_d = fetch_pc_q + PC_SIZE'(INST_BYTES);
            if (rsp_keep) rsp_pc_d   = rsp_pc_q + PC_SIZE'(INST_BYTES);
            if (bus.imemRspValid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (rsp_entry),
        .pop_i   (pop),
        .flush_i (bus.brTaken),
        .head_o  (head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );
endmodule

// File: doc/if_stage_pipe.md
Name: if_stage_pipe

Overview:
Parametrised instruction-fetch stage with a decoupled request/response instruction-memory interface and a flushable fetch queue.
- Issues sequential fetches ahead of decode, up to FIFO_DEPTH in flight or buffered.
- Computes sign-extended, word-scaled branch targets.
- Squashes wrong-path fetches on redirect.
- Presents PC and instruction to the ID stage through a valid/ready handshake.

Parameters:
INST_SIZE, 32, instruction width in bits
PC_SIZE, 32, PC/address width in bits
BR_OFFSET_SIZE, 16, branch offset width in instruction words, signed
FIFO_DEPTH, 4, fetch queue entries; also the credit limit (power of two, >=2)
RESET_PC, 0, PC value loaded on reset (word aligned)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
brTaken  in  1  redirect request from EX, single-cycle pulse
brPC  in  PC_SIZE  PC of the branch instruction
brOffset  in  BR_OFFSET_SIZE  signed word offset
imemReq  out  1  fetch request valid
imemAddr  out  PC_SIZE  fetch address
imemGnt  in  1  memory accepted the request this cycle
imemRspValid  in  1  in-order response valid
imemRspData  in  INST_SIZE  response instruction
outValid  out  1  PC/instruction valid to ID
outReady  in  1  ID accepts this cycle
PC  out  PC_SIZE  PC of the presented instruction
instruction  out  INST_SIZE  presented instruction

Behaviour:
- Reset (rst low, asynchronous):
  - fetchPC=RESET_PC, rspPC=RESET_PC.
  - outstanding=0, dropCount=0, FIFO empty.
  - Outputs: outValid=0, imemReq=0.
  - The memory shares this reset; no responses arrive for pre-reset requests.
- Target = brPC + 4 + (sext(brOffset) << 2). Arithmetic is modulo 2^PC_SIZE, so wrap-around is silent.
- Issue rule:
  - imemReq = !brTaken && (outstanding + fifoCount < FIFO_DEPTH). Compare at full counter width, clog2(FIFO_DEPTH+1) bits.
  - imemAddr = fetchPC, held stable while imemReq=1 and imemGnt=0.
  - On imemReq && imemGnt: fetchPC += 4 and outstanding increments.
- Response rule:
  - On imemRspValid, outstanding decrements.
  - If dropCount>0, the response is discarded and dropCount decrements.
  - Otherwise {rspPC, imemRspData} is pushed to the FIFO and rspPC += 4.
  - Credits guarantee the FIFO is never full on a push; verification asserts this.
- Output:
  - outValid = FIFO non-empty. PC/instruction come from the FIFO head (show-ahead).
  - Pop on outValid && outReady.
  - Latency from response to output is 1 cycle. Simultaneous push and pop is legal at any occupancy.
- Stall: with outReady=0 the head entry is held stable. Issue continues until credits are exhausted.
- Redirect (brTaken=1):
  - Next cycle: fetchPC=target, rspPC=target, FIFO flushed, outValid=0.
  - dropCount = outstanding, plus any grant this cycle, minus any response this cycle. A response arriving in the redirect cycle is dropped.
  - imemReq is forced 0 in the redirect cycle.
  - Redirect has priority over push, pop and issue. Any pop that cycle is ignored.
- Redirect while dropCount>0: dropCount is recomputed by the same rule; old wrong-path responses stay counted.
- First correct-path request issues the cycle after redirect. Credit still counts outstanding dropped fetches.

Optional Feature:
IF_FIFO_BYPASS_EN
- Defined: when the FIFO is empty, no redirect occurs and the response is not dropped, the response drives PC/instruction with outValid=1 combinationally.
  - If outReady=1 it is consumed without a push (0-cycle latency).
  - If outReady=0 it is pushed normally.
- Undefined: always 1-cycle latency through the FIFO. All other behaviour is identical.

Decomposition:
- Package if_pkg:
  - INST_BYTES=4.
  - typedef fetch_entry_t {pc, inst} sized by the parameters.
  - function sext_target(brPC, brOffset).
- One sub-module, fetch_fifo: synchronous FIFO with push, pop, flush, count, show-ahead head, and reset on the same async active-low rst. It is instantiated once.
- Credit and drop counters stay in if_stage_pipe.

Test Plan:
1. Reset release, imemGnt=1 always, memory latency 1, outReady=1 -> imemAddr 0,4,8,...; ID sees PC 0,4,8 with matching data, one per cycle after the pipeline fills.
2. outReady=0 for 10 cycles, latency 1 -> exactly 4 requests granted, then imemReq=0. PC=0 held on outputs. On release, PCs 0..12 drain in order and issue resumes at 16.
3. imemGnt stuck 0 for 3 cycles with imemReq=1 -> imemAddr is stable and outstanding is unchanged.
4. Memory latency 3, 3 requests outstanding; brTaken with brPC=0x20, brOffset=-2 -> next imemAddr 0x1C. The 3 stale responses are dropped. The first output is PC 0x1C.
5. brTaken in the same cycle as imemRspValid and outValid&&outReady -> the response is dropped, no pop is counted, and outValid=0 next cycle.
6. Assert rst low mid-burst with the FIFO holding 3 entries -> outValid=0 and imemReq=0 immediately. After release, fetch restarts at RESET_PC.
